weight_tile_fifo: RTL and testbench
===================================

Name: weight_tile_fifo

Overview:
Row-wide weight buffer directly upstream of the control unit and systolic array. Accepts weight rows from the memory interface, holds up to DEPTH_TILES complete tiles of ARRAY_DIM rows, and releases one tile as a back-to-back burst while the control unit asserts load_weights. Its rd_valid_o drives the control unit's weight_fifo_valid_output input. That input is counted to 32 beats per tile.

Parameters:
DATA_W, 8, bits per weight element
ARRAY_DIM, 32, rows per tile and elements per row
DEPTH_TILES, 2, tile capacity; total storage = ARRAY_DIM*DEPTH_TILES rows

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
flush_i  in  1  synchronous clear of all contents and state
wr_valid_i  in  1  write row valid
wr_ready_o  out  1  space available; a write happens when wr_valid_i && wr_ready_o
wr_data_i  in  ARRAY_DIM*DATA_W  one weight row, element 0 in the LSBs
rd_en_i  in  1  pop request (load_weights_o from the control unit)
rd_valid_o  out  1  rd_data_o holds a valid row this cycle
rd_data_o  out  ARRAY_DIM*DATA_W  popped row
rd_row_idx_o  out  $clog2(ARRAY_DIM)  row index within the tile of the current rd_data_o
tile_rdy_o  out  1  at least one full tile is stored, or a burst is in progress
tile_done_o  out  1  one-cycle pulse, coincident with the last row's rd_valid_o
count_o  out  $clog2(ARRAY_DIM*DEPTH_TILES+1)  rows currently stored

Behaviour:
- Reset (rst_i low, async): pointers, count, FSM and row counter cleared. All outputs 0, except wr_ready_o = 1 after reset release. rd_data_o is reset to 0.
- flush_i has the same effect as reset, synchronously. It takes priority over any write or read in the same cycle.
- Storage is circular, indexed by write and read pointers. Both wrap at ARRAY_DIM*DEPTH_TILES-1 back to 0.
- wr_ready_o = (count < capacity). It is a registered count comparison only, with no combinational path from rd_en_i.
- A pop in the same cycle as a write at full does not admit the write.
- FSM states:
  - IDLE → STREAM when rd_en_i=1 and count >= ARRAY_DIM.
  - STREAM pops one row every cycle rd_en_i=1 and holds (bubble, no pop) when rd_en_i=0.
  - STREAM → IDLE after row ARRAY_DIM-1 is popped.
  - In IDLE, rd_en_i with fewer than ARRAY_DIM rows stored is ignored: no pop and no valid.
- Read latency is 1 cycle. A pop in cycle N gives rd_valid_o=1 and rd_data_o=row in cycle N+1. rd_row_idx_o runs 0..ARRAY_DIM-1 for the rows of one tile.
- tile_done_o is high with rd_valid_o of row ARRAY_DIM-1.
- If rd_en_i is held continuously, back-to-back tiles are allowed. The first pop of the next tile may occur in the cycle after the last pop of the previous tile if a full tile is present.
- count: +1 on a write, -1 on a pop, unchanged when both happen in the same cycle. Width is $clog2(capacity+1).
- A write during STREAM is legal and lands behind the tile being read.
- tile_rdy_o = (count >= ARRAY_DIM) || (state == STREAM).

Optional Feature:
Macro WEIGHT_FIFO_ERR_FLAGS_EN.
- When defined, add two outputs, each sticky until reset or flush:
  - ovf_err_o (1): set when wr_valid_i=1 while wr_ready_o=0. The write is still dropped.
  - udf_err_o (1): set when rd_en_i=1 in IDLE with count < ARRAY_DIM.
- When undefined, neither port exists and behaviour is otherwise identical.

Decomposition:
- Shared package Weight_types holds:
  - ARRAY_DIM and DATA_W defaults;
  - typedef weight_row_t = logic [ARRAY_DIM*DATA_W-1:0];
  - enum wfifo_state_t {IDLE, STREAM}.
- One sub-module, wfifo_ram: a simple dual-port memory with synchronous read, a single clock and no reset on the array. The top keeps pointers, count, FSM and flags.

Test Plan:
- Write 32 rows with values 0x01..0x20 in element 0, then hold rd_en_i for 32 cycles. Expect rd_valid_o on cycles 1..32 with rows in order, rd_row_idx_o 0..31, tile_done_o only on the last row, count_o ending at 0.
- Write 31 rows, then assert rd_en_i. Expect no rd_valid_o and tile_rdy_o=0. Write the 32nd row and expect the burst to start the cycle after rd_en_i is seen with count=32.
- Fill to 64 rows. Expect wr_ready_o=0 and a further write not stored (ovf_err_o=1 when WEIGHT_FIFO_ERR_FLAGS_EN). Stream two tiles with rd_en_i held 64 cycles; expect 64 contiguous valids and two tile_done_o pulses.
- Deassert rd_en_i for 3 cycles mid-burst at row 10. Expect rd_valid_o low for 3 cycles, then row 10 resumes with no row lost or duplicated.
- Write and pop simultaneously at count=40. Expect count_o stays 40 and the pointers wrap correctly past row 63.
- Drive rst_i low at row 15 of a burst. Expect all outputs 0 immediately. After release, expect count_o=0, wr_ready_o=1, and state IDLE.

Source files
------------

// File: rtl/weight_tile_fifo_pkg.sv
// Shared sizing defaults, row type and FSM state encoding for the weight tile FIFO.
// Consumed by weight_tile_fifo, wfifo_ram and their testbench.
package Weight_types;

  localparam int DATA_W      = 8;
  localparam int ARRAY_DIM   = 32;
  localparam int DEPTH_TILES = 2;

  typedef logic [ARRAY_DIM*DATA_W-1:0] weight_row_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } wfifo_state_t;

endpackage

// File: rtl/weight_tile_fifo_ram.sv
// wfifo_ram: single-clock simple dual-port row store with a registered read port.
// Only the read register is reset; the storage array itself is never cleared.
module wfifo_ram #(
  parameter int WIDTH  = 256,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);
  import Weight_types::*;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      r_mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Holds the last popped row between pops so the output only changes on a read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_rd_data <= '0;
    end else if (clr_i) begin
      r_rd_data <= '0;
    end else if (rd_en_i) begin
      r_rd_data <= r_mem[rd_addr_i];
    end
  end

  assign rd_data_o = r_rd_data;

endmodule

// File: rtl/weight_tile_fifo.sv
// weight_tile_fifo: buffers weight rows and releases whole tiles as bursts to the control unit.
// Optional sticky overflow/underflow flags are built when WEIGHT_FIFO_ERR_FLAGS_EN is defined.
module weight_tile_fifo #(
  parameter int DATA_W      = Weight_types::DATA_W,
  parameter int ARRAY_DIM   = Weight_types::ARRAY_DIM,
  parameter int DEPTH_TILES = Weight_types::DEPTH_TILES
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         flush_i,
  input  logic                                         wr_valid_i,
  output logic                                         wr_ready_o,
  input  logic [ARRAY_DIM*DATA_W-1:0]                  wr_data_i,
  input  logic                                         rd_en_i,
  output logic                                         rd_valid_o,
  output logic [ARRAY_DIM*DATA_W-1:0]                  rd_data_o,
  output logic [$clog2(ARRAY_DIM)-1:0]                 rd_row_idx_o,
  output logic                                         tile_rdy_o,
  output logic                                         tile_done_o,
`ifdef WEIGHT_FIFO_ERR_FLAGS_EN
  output logic [$clog2(ARRAY_DIM*DEPTH_TILES+1)-1:0]   count_o,
  output logic                                         ovf_err_o,
  output logic                                         udf_err_o
`else
  output logic [$clog2(ARRAY_DIM*DEPTH_TILES+1)-1:0]   count_o
`endif
);
  import Weight_types::*;

  localparam int ROW_W = ARRAY_DIM*DATA_W;
  localparam int CAP   = ARRAY_DIM*DEPTH_TILES;
  localparam int PTR_W = $clog2(CAP);
  localparam int IDX_W = $clog2(ARRAY_DIM);
  localparam int CNT_W = $clog2(CAP+1);

  wfifo_state_t     r_state;
  wfifo_state_t     w_state_next;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [IDX_W-1:0] r_pop_idx;
  logic [IDX_W-1:0] w_pop_idx_next;
  logic [IDX_W-1:0] r_row_idx;
  logic             r_rd_valid;
  logic             r_tile_done;
  logic             w_wr_ready;
  logic             w_tile_avail;
  logic             w_wr;
  logic             w_pop;
  logic             w_last;
  logic [ROW_W-1:0] w_ram_rd_data;

  assign w_wr_ready   = (r_count < CNT_W'(CAP));
  assign w_tile_avail = (r_count >= CNT_W'(ARRAY_DIM));
  assign w_wr         = wr_valid_i && w_wr_ready && !flush_i;

  // A burst is only started with a whole tile stored, so STREAM never runs dry.
  always_comb begin
    w_state_next   = r_state;
    w_pop          = 1'b0;
    w_last         = 1'b0;
    w_pop_idx_next = r_pop_idx;
    unique case (r_state)
      IDLE:    w_pop = rd_en_i && w_tile_avail && !flush_i;
      STREAM:  w_pop = rd_en_i && !flush_i;
      default: w_pop = 1'b0;
    endcase
    if (w_pop) begin
      w_last         = (r_pop_idx == IDX_W'(ARRAY_DIM-1));
      w_pop_idx_next = w_last ? '0 : r_pop_idx + 1'b1;
      w_state_next   = w_last ? IDLE : STREAM;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_idx   <= '0;
      r_row_idx   <= '0;
      r_rd_valid  <= 1'b0;
      r_tile_done <= 1'b0;
    end else if (flush_i) begin
      r_state     <= IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_pop_idx   <= '0;
      r_row_idx   <= '0;
      r_rd_valid  <= 1'b0;
      r_tile_done <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pop_idx   <= w_pop_idx_next;
      r_rd_valid  <= w_pop;
      r_tile_done <= w_pop && w_last;
      if (w_pop) begin
        r_row_idx <= r_pop_idx;
        r_rd_ptr  <= (r_rd_ptr == PTR_W'(CAP-1)) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(CAP-1)) ? '0 : r_wr_ptr + 1'b1;
      end
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  wfifo_ram #(
    .WIDTH (ROW_W),
    .DEPTH (CAP),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (flush_i),
    .wr_en_i  (w_wr),
    .wr_addr_i(r_wr_ptr),
    .wr_data_i(wr_data_i),
    .rd_en_i  (w_pop),
    .rd_addr_i(r_rd_ptr),
    .rd_data_o(w_ram_rd_data)
  );

  assign wr_ready_o   = w_wr_ready;
  assign rd_valid_o   = r_rd_valid;
  assign rd_data_o    = w_ram_rd_data;
  assign rd_row_idx_o = r_row_idx;
  assign tile_rdy_o   = w_tile_avail || (r_state == STREAM);
  assign tile_done_o  = r_tile_done;
  assign count_o      = r_count;

`ifdef WEIGHT_FIFO_ERR_FLAGS_EN
  logic r_ovf_err;
  logic r_udf_err;

  // Both flags stay set until reset or flush so software can inspect them later.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else if (flush_i) begin
      r_ovf_err <= 1'b0;
      r_udf_err <= 1'b0;
    end else begin
      if (wr_valid_i && !w_wr_ready) begin
        r_ovf_err <= 1'b1;
      end
      if (rd_en_i && (r_state == IDLE) && !w_tile_avail) begin
        r_udf_err <= 1'b1;
      end
    end
  end

  assign ovf_err_o = r_ovf_err;
  assign udf_err_o = r_udf_err;
`endif

endmodule

// File: tb/tb_weight_tile_fifo.sv
// Directed testbench for weight_tile_fifo: fill/burst, partial tile, full, bubbles, wrap, flush, reset.
// Error-flag checks are included when WEIGHT_FIFO_ERR_FLAGS_EN is defined.
module tb_weight_tile_fifo;
  import Weight_types::*;

  localparam int ROW_W = ARRAY_DIM*DATA_W;
  localparam int CAP   = ARRAY_DIM*DEPTH_TILES;
  localparam int IDX_W = $clog2(ARRAY_DIM);
  localparam int CNT_W = $clog2(CAP+1);

  logic              clock = 1'b0;
  logic              rstN;
  logic              flush;
  logic              wrValid;
  logic              wrReady;
  weight_row_t       wrData;
  logic              rdEn;
  logic              rdValid;
  weight_row_t       rdData;
  logic [IDX_W-1:0]  rowIdx;
  logic              tileRdy;
  logic              tileDone;
  logic [CNT_W-1:0]  count;
`ifdef WEIGHT_FIFO_ERR_FLAGS_EN
  logic              ovfErr;
  logic              udfErr;
`endif

  int errors;
  int checks;
  int wrSeq;
  int rdSeq;
  int doneSeen;

  always #5 clock = ~clock;

  weight_tile_fifo #(
    .DATA_W     (DATA_W),
    .ARRAY_DIM  (ARRAY_DIM),
    .DEPTH_TILES(DEPTH_TILES)
  ) dut (
    .clk_i       (clock),
    .rst_i       (rstN),
    .flush_i     (flush),
    .wr_valid_i  (wrValid),
    .wr_ready_o  (wrReady),
    .wr_data_i   (wrData),
    .rd_en_i     (rdEn),
    .rd_valid_o  (rdValid),
    .rd_data_o   (rdData),
    .rd_row_idx_o(rowIdx),
    .tile_rdy_o  (tileRdy),
    .tile_done_o (tileDone),
`ifdef WEIGHT_FIFO_ERR_FLAGS_EN
    .count_o     (count),
    .ovf_err_o   (ovfErr),
    .udf_err_o   (udfErr)
`else
    .count_o     (count)
`endif
  );

  // Element 0 carries the sequence number; other elements make every row distinct.
  function automatic weight_row_t rowPattern(input int seq);
    weight_row_t r;
    r = '0;
    for (int e = 0; e < ARRAY_DIM; e++) begin
      r[e*DATA_W +: DATA_W] = DATA_W'(seq + e*37);
    end
    r[DATA_W +: DATA_W] = DATA_W'(seq >>> 8);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [ROW_W-1:0] observed,
                             input logic [ROW_W-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wrV, input logic rd, input logic fl);
    wrValid = wrV;
    wrData  = rowPattern(wrSeq);
    rdEn    = rd;
    flush   = fl;
    @(posedge clock);
    #1;
  endtask

  task automatic writeRows(input int n);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      wrSeq++;
    end
    wrValid = 1'b0;
  endtask

  // Every rd_en cycle pops; the extra final cycle drains the one-cycle read latency.
  task automatic readBurst(input int nCycles, input int gapStart, input int gapLen,
                           input logic wrEach, input logic holdCount, input int heldCount);
    int   expIdx;
    logic en;
    expIdx = 0;
    for (int i = 0; i <= nCycles; i++) begin
      en = (i < nCycles) && !((i >= gapStart) && (i < gapStart + gapLen));
      applyStimulus(wrEach && en, en, 1'b0);
      if (wrEach && en) wrSeq++;
      checkOutput("burst_valid", ROW_W'(rdValid), ROW_W'(en));
      if (en) begin
        checkOutput("burst_data", rdData, rowPattern(rdSeq));
        checkOutput("burst_idx", ROW_W'(rowIdx), ROW_W'(expIdx));
        checkOutput("burst_done", ROW_W'(tileDone), ROW_W'(expIdx == ARRAY_DIM-1));
        if (tileDone) doneSeen++;
        if (holdCount) checkOutput("burst_count_hold", ROW_W'(count), ROW_W'(heldCount));
        rdSeq++;
        expIdx = (expIdx + 1) % ARRAY_DIM;
      end else begin
        checkOutput("bubble_done", ROW_W'(tileDone), ROW_W'(0));
      end
    end
    rdEn = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    errors   = 0;
    checks   = 0;
    wrSeq    = 1;
    rdSeq    = 1;
    doneSeen = 0;
    rstN     = 1'b0;
    flush    = 1'b0;
    wrValid  = 1'b0;
    rdEn     = 1'b0;
    wrData   = '0;

    #12;
    checkOutput("rst_valid", ROW_W'(rdValid), ROW_W'(0));
    checkOutput("rst_data", rdData, ROW_W'(0));
    checkOutput("rst_count", ROW_W'(count), ROW_W'(0));
    checkOutput("rst_tile_rdy", ROW_W'(tileRdy), ROW_W'(0));
    checkOutput("rst_tile_done", ROW_W'(tileDone), ROW_W'(0));
    checkOutput("rst_idx", ROW_W'(rowIdx), ROW_W'(0));
    rstN = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("post_rst_wr_ready", ROW_W'(wrReady), ROW_W'(1));
    checkOutput("post_rst_count", ROW_W'(count), ROW_W'(0));

    $display("[TB] one tile fill and burst");
    writeRows(32);
    checkOutput("t1_count", ROW_W'(count), ROW_W'(32));
    checkOutput("t1_tile_rdy", ROW_W'(tileRdy), ROW_W'(1));
    readBurst(32, 1000, 0, 1'b0, 1'b0, 0);
    checkOutput("t1_count_end", ROW_W'(count), ROW_W'(0));
    checkOutput("t1_tile_rdy_end", ROW_W'(tileRdy), ROW_W'(0));

    $display("[TB] partial tile ignored until complete");
    writeRows(31);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("t2_no_valid", ROW_W'(rdValid), ROW_W'(0));
      checkOutput("t2_no_tile", ROW_W'(tileRdy), ROW_W'(0));
      checkOutput("t2_count", ROW_W'(count), ROW_W'(31));
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    wrSeq++;
    checkOutput("t2_last_wr_valid", ROW_W'(rdValid), ROW_W'(0));
    checkOutput("t2_last_wr_count", ROW_W'(count), ROW_W'(32));
    checkOutput("t2_last_wr_tile", ROW_W'(tileRdy), ROW_W'(1));
    readBurst(32, 1000, 0, 1'b0, 1'b0, 0);
`ifdef WEIGHT_FIFO_ERR_FLAGS_EN
    checkOutput("t2_udf", ROW_W'(udfErr), ROW_W'(1));
`endif

    $display("[TB] flush beats a same-cycle write");
    writeRows(5);
    checkOutput("fl_count_pre", ROW_W'(count), ROW_W'(5));
    applyStimulus(1'b1, 1'b0, 1'b1);
    flush = 1'b0;
    wrValid = 1'b0;
    checkOutput("fl_count", ROW_W'(count), ROW_W'(0));
    checkOutput("fl_wr_ready", ROW_W'(wrReady), ROW_W'(1));
    checkOutput("fl_data", rdData, ROW_W'(0));
    checkOutput("fl_tile_rdy", ROW_W'(tileRdy), ROW_W'(0));
`ifdef WEIGHT_FIFO_ERR_FLAGS_EN
    checkOutput("fl_udf", ROW_W'(udfErr), ROW_W'(0));
`endif
    rdSeq = wrSeq;

    $display("[TB] full buffer and two-tile burst");
    writeRows(64);
    checkOutput("t3_count_full", ROW_W'(count), ROW_W'(64));
    checkOutput("t3_wr_ready", ROW_W'(wrReady), ROW_W'(0));
    applyStimulus(1'b1, 1'b0, 1'b0);
    wrValid = 1'b0;
    checkOutput("t3_dropped_count", ROW_W'(count), ROW_W'(64));
`ifdef WEIGHT_FIFO_ERR_FLAGS_EN
    checkOutput("t3_ovf", ROW_W'(ovfErr), ROW_W'(1));
`endif
    doneSeen = 0;
    readBurst(64, 1000, 0, 1'b0, 1'b0, 0);
    checkOutput("t3_done_pulses", ROW_W'(doneSeen), ROW_W'(2));
    checkOutput("t3_count_end", ROW_W'(count), ROW_W'(0));

    $display("[TB] three-cycle bubble at row 10");
    writeRows(32);
    readBurst(35, 10, 3, 1'b0, 1'b0, 0);
    checkOutput("t4_count_end", ROW_W'(count), ROW_W'(0));

    $display("[TB] simultaneous write and pop at count 40 across the wrap");
    writeRows(40);
    checkOutput("t5_count_pre", ROW_W'(count), ROW_W'(40));
    readBurst(32, 1000, 0, 1'b1, 1'b1, 40);
    checkOutput("t5_count_mid", ROW_W'(count), ROW_W'(40));
    readBurst(32, 1000, 0, 1'b0, 1'b0, 0);
    checkOutput("t5_count_end", ROW_W'(count), ROW_W'(8));

    $display("[TB] async reset mid-burst");
    writeRows(24);
    checkOutput("t6_count_pre", ROW_W'(count), ROW_W'(32));
    readBurst(15, 1000, 0, 1'b0, 1'b0, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("t6_row15_valid", ROW_W'(rdValid), ROW_W'(1));
    checkOutput("t6_row15_idx", ROW_W'(rowIdx), ROW_W'(15));
    checkOutput("t6_row15_data", rdData, rowPattern(rdSeq));
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("t6_rst_valid", ROW_W'(rdValid), ROW_W'(0));
    checkOutput("t6_rst_data", rdData, ROW_W'(0));
    checkOutput("t6_rst_idx", ROW_W'(rowIdx), ROW_W'(0));
    checkOutput("t6_rst_count", ROW_W'(count), ROW_W'(0));
    checkOutput("t6_rst_tile_rdy", ROW_W'(tileRdy), ROW_W'(0));
    checkOutput("t6_rst_tile_done", ROW_W'(tileDone), ROW_W'(0));
    #2;
    rstN = 1'b1;
    rdEn = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("t6_rel_count", ROW_W'(count), ROW_W'(0));
    checkOutput("t6_rel_wr_ready", ROW_W'(wrReady), ROW_W'(1));
    checkOutput("t6_rel_tile_rdy", ROW_W'(tileRdy), ROW_W'(0));
`ifdef WEIGHT_FIFO_ERR_FLAGS_EN
    checkOutput("t6_rel_ovf", ROW_W'(ovfErr), ROW_W'(0));
`endif
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("t6_idle_no_valid", ROW_W'(rdValid), ROW_W'(0));
    end
    rdSeq = wrSeq;
    writeRows(32);
    readBurst(32, 1000, 0, 1'b0, 1'b0, 0);
    checkOutput("t6_count_end", ROW_W'(count), ROW_W'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
